// File: rtl/dcache_wt_pkg.sv
// Shared definitions for the write-through direct-mapped data cache.
package dcache_wt_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int DEF_LINES = 16;
    localparam int DEF_WORDS = 4;

    localparam logic [1:0] MEM_NONE  = 2'b00;
    localparam logic [1:0] MEM_LOAD  = 2'b01;
    localparam logic [1:0] MEM_STORE = 2'b10;

endpackage

// File: rtl/dc_line_store.sv
// Tag, valid and data storage for the cache: one combinational read port,
// a line-fill write port, a single-word write port and a per-line valid clear.
module dc_line_store
    import dcache_wt_pkg::*;
#(
    parameter int LINES = DEF_LINES,
    parameter int WORDS = DEF_WORDS,
    parameter int TAG_W = 30 - $clog2(LINES) - $clog2(WORDS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [$clog2(LINES)-1:0] rd_index,
    input  logic [$clog2(WORDS)-1:0] rd_offset,
    output logic                     rd_valid,
    output logic [TAG_W-1:0]         rd_tag,
    output logic [31:0]              rd_data,
    input  logic                     clr_en,
    input  logic [$clog2(LINES)-1:0] clr_index,
    input  logic                     fill_en,
    input  logic                     fill_last,
    input  logic [$clog2(LINES)-1:0] fill_index,
    input  logic [$clog2(WORDS)-1:0] fill_offset,
    input  logic [TAG_W-1:0]         fill_tag,
    input  logic [31:0]              fill_data,
    input  logic                     wr_en,
    input  logic [$clog2(LINES)-1:0] wr_index,
    input  logic [$clog2(WORDS)-1:0] wr_offset,
    input  logic [31:0]              wr_data
);

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [31:0]      data_q [LINES*WORDS];

    // A line only becomes valid once its last word lands, so an interrupted
    // fill can never be seen as a hit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
        end else begin
            if (clr_en)
                valid_q[clr_index] <= 1'b0;
            if (fill_en && fill_last)
                valid_q[fill_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_en)
            data_q[{fill_index, fill_offset}] <= fill_data;
        else if (wr_en)
            data_q[{wr_index, wr_offset}] <= wr_data;
        if (fill_en && fill_last)
            tag_q[fill_index] <= fill_tag;
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_data  = data_q[{rd_index, rd_offset}];

endmodule

// File: rtl/dcache_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache sitting between
// the memory pipeline stage and a single-outstanding-request backing memory.
module dcache_wt
    import dcache_wt_pkg::*;
#(
    parameter int LINES = DEF_LINES,
    parameter int WORDS = DEF_WORDS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  MEM,
    input  logic [31:0] Addr,
    input  logic [31:0] Wdata,
    output logic [31:0] Rdata,
    output logic        BUSY,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output state_e      dbg_state
);

    // Backing-memory handshake: mem_req/mem_we/mem_addr/mem_wdata are held
    // stable from the first FILL/WRITE cycle until the cycle mem_ack is seen
    // high at a rising edge; mem_ack without mem_req is ignored.

    localparam int OFF_W = $clog2(WORDS);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 30 - OFF_W - IDX_W;

    logic [OFF_W-1:0] a_off;
    logic [IDX_W-1:0] a_idx;
    logic [TAG_W-1:0] a_tag;
    logic             unused_addr_bits;

    assign a_off            = Addr[OFF_W+1:2];
    assign a_idx            = Addr[IDX_W+OFF_W+1:OFF_W+2];
    assign a_tag            = Addr[31:IDX_W+OFF_W+2];
    assign unused_addr_bits = ^Addr[1:0];

    state_e           state_q, state_d;
    logic [OFF_W-1:0] cnt_q, cnt_d;
    logic [TAG_W-1:0] lat_tag_q;
    logic [IDX_W-1:0] lat_idx_q;
    logic             lat_en;

    logic             rd_valid;
    logic [TAG_W-1:0] rd_tag;
    logic [31:0]      rd_data;
    logic             hit, is_load, is_store;
    logic             clr_en, fill_en, fill_last, wr_en, busy;

    assign hit      = rd_valid && (rd_tag == a_tag);
    assign is_store = MEM[1];
    assign is_load  = (MEM == MEM_LOAD);

    dc_line_store #(.LINES(LINES), .WORDS(WORDS), .TAG_W(TAG_W)) u_store (
        .clk        (clk),
        .rst        (rst),
        .rd_index   (a_idx),
        .rd_offset  (a_off),
        .rd_valid   (rd_valid),
        .rd_tag     (rd_tag),
        .rd_data    (rd_data),
        .clr_en     (clr_en),
        .clr_index  (a_idx),
        .fill_en    (fill_en),
        .fill_last  (fill_last),
        .fill_index (lat_idx_q),
        .fill_offset(cnt_q),
        .fill_tag   (lat_tag_q),
        .fill_data  (mem_rdata),
        .wr_en      (wr_en),
        .wr_index   (a_idx),
        .wr_offset  (a_off),
        .wr_data    (Wdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            lat_tag_q <= '0;
            lat_idx_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (lat_en) begin
                lat_tag_q <= a_tag;
                lat_idx_q <= a_idx;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        busy      = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        Rdata     = '0;
        lat_en    = 1'b0;
        clr_en    = 1'b0;
        fill_en   = 1'b0;
        fill_last = 1'b0;
        wr_en     = 1'b0;
        case (state_q)
            IDLE: begin
                if (is_store) begin
                    busy    = 1'b1;
                    state_d = WRITE;
                end else if (is_load) begin
                    if (hit) begin
                        Rdata = rd_data;
                    end else begin
                        busy    = 1'b1;
                        lat_en  = 1'b1;
                        clr_en  = 1'b1;
                        cnt_d   = '0;
                        state_d = FILL;
                    end
                end
            end
            FILL: begin
                busy     = 1'b1;
                mem_req  = 1'b1;
                mem_addr = {lat_tag_q, lat_idx_q, cnt_q, 2'b00};
                if (mem_ack) begin
                    fill_en = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == OFF_W'(WORDS - 1)) begin
                        fill_last = 1'b1;
                        state_d   = DONE;
                    end
                end
            end
            WRITE: begin
                busy      = 1'b1;
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {Addr[31:2], 2'b00};
                mem_wdata = Wdata;
                if (mem_ack) begin
                    wr_en   = hit;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (is_load)
                    Rdata = rd_data;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A load miss raises BUSY combinationally in IDLE; hold it low under reset.
    assign BUSY      = busy & rst;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_dcache_wt.sv
// Self-checking bench for dcache_wt: directed scenarios followed by random
// loads/stores, all checked against a line-level cache and memory model.
module tb_dcache_wt;
    import dcache_wt_pkg::*;

    localparam int LINES = 16;
    localparam int WORDS = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  MEM;
    logic [31:0] Addr, Wdata, Rdata;
    logic        BUSY, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack;
    state_e      dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_q[$];
    logic [31:0] bmem [logic [31:0]];
    bit          mvalid [LINES];
    logic [31:0] mtag   [LINES];
    logic [31:0] mdata  [LINES][WORDS];

    dcache_wt #(.LINES(LINES), .WORDS(WORDS)) dut (
        .clk      (clk),
        .rst      (rst),
        .MEM      (MEM),
        .Addr     (Addr),
        .Wdata    (Wdata),
        .Rdata    (Rdata),
        .BUSY     (BUSY),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ack  (mem_ack),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_b(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] bword(input logic [31:0] a);
        if (bmem.exists(a))
            return bmem[a];
        return a ^ 32'h5A5A_0000;
    endfunction

    function automatic int f_idx(input logic [31:0] a);
        return int'((a / (4 * WORDS)) % LINES);
    endfunction

    function automatic int f_off(input logic [31:0] a);
        return int'((a / 4) % WORDS);
    endfunction

    function automatic logic [31:0] f_tag(input logic [31:0] a);
        return a / (4 * WORDS * LINES);
    endfunction

    // Load; abort_acks > 0 asserts reset after that many fill acks.
    task automatic do_load(input logic [31:0] a, input int abort_acks);
        int          idx, off, acks, gap, budget, stop;
        logic [31:0] tag, base;
        logic [31:0] line [WORDS];
        bit          hit;
        idx    = f_idx(a);
        off    = f_off(a);
        tag    = f_tag(a);
        hit    = mvalid[idx] && (mtag[idx] == tag);
        acks   = 0;
        budget = 60;
        MEM    = MEM_LOAD;
        Addr   = a;
        Wdata  = $urandom;
        #1;
        check_b("load_busy", BUSY, !hit);
        if (hit) begin
            check("hit_rdata", Rdata, mdata[idx][off]);
            check_b("hit_no_req", mem_req, 1'b0);
            tick();
            MEM = MEM_NONE;
            #1;
            check("idle_rdata", Rdata, 32'h0);
            return;
        end
        base = a - (a % (4 * WORDS));
        for (int i = 0; i < WORDS; i++)
            exp_q.push_back(base + 32'(4 * i));
        stop = (abort_acks > 0) ? abort_acks : WORDS;
        gap  = $urandom_range(0, 2);
        while (acks < stop) begin
            tick();
            mem_ack = 1'b0;
            budget--;
            if (budget == 0) begin
                check("fill_timeout", acks, stop);
                exp_q.delete();
                break;
            end
            check_b("fill_busy", BUSY, 1'b1);
            check_b("fill_req", mem_req, 1'b1);
            check_b("fill_we", mem_we, 1'b0);
            check("fill_addr", mem_addr, exp_q[0]);
            if (gap == 0) begin
                line[acks] = bword(exp_q[0]);
                mem_rdata  = line[acks];
                mem_ack    = 1'b1;
                void'(exp_q.pop_front());
                acks++;
                gap = $urandom_range(0, 2);
                #1;
                check_b("ack_busy", BUSY, 1'b1);
            end else begin
                gap--;
            end
        end
        tick();
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        if (abort_acks > 0) begin
            rst = 1'b0;
            #1;
            check_b("rst_busy", BUSY, 1'b0);
            check_b("rst_req", mem_req, 1'b0);
            check_b("rst_we", mem_we, 1'b0);
            check("rst_addr", mem_addr, 32'h0);
            check("rst_wdata", mem_wdata, 32'h0);
            check("rst_rdata", Rdata, 32'h0);
            foreach (mvalid[i]) mvalid[i] = 1'b0;
            exp_q.delete();
            MEM = MEM_NONE;
            #2;
            rst = 1'b1;
            return;
        end
        check_b("done_busy", BUSY, 1'b0);
        check_b("done_req", mem_req, 1'b0);
        check("done_rdata", Rdata, line[off]);
        check("fill_words_left", exp_q.size(), 0);
        mvalid[idx] = 1'b1;
        mtag[idx]   = tag;
        for (int i = 0; i < WORDS; i++)
            mdata[idx][i] = line[i];
        tick();
        MEM = MEM_NONE;
        #1;
        check("idle_rdata", Rdata, 32'h0);
        check_b("idle_busy", BUSY, 1'b0);
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d);
        int          idx, off, gap, budget;
        logic [31:0] tag, waddr;
        bit          hit, acked;
        idx    = f_idx(a);
        off    = f_off(a);
        tag    = f_tag(a);
        waddr  = a - (a % 4);
        hit    = mvalid[idx] && (mtag[idx] == tag);
        acked  = 1'b0;
        budget = 40;
        MEM    = ($urandom_range(0, 1) == 1) ? 2'b11 : MEM_STORE;
        Addr   = a;
        Wdata  = d;
        #1;
        check_b("st_busy0", BUSY, 1'b1);
        check_b("st_idle_noreq", mem_req, 1'b0);
        gap = $urandom_range(0, 2);
        while (!acked) begin
            tick();
            budget--;
            if (budget == 0) begin
                check_b("st_timeout", acked, 1'b1);
                break;
            end
            check_b("st_busy", BUSY, 1'b1);
            check_b("st_req", mem_req, 1'b1);
            check_b("st_we", mem_we, 1'b1);
            check("st_addr", mem_addr, waddr);
            check("st_wdata", mem_wdata, d);
            if (gap == 0) begin
                mem_ack   = 1'b1;
                mem_rdata = $urandom;
                acked     = 1'b1;
            end else begin
                gap--;
            end
        end
        tick();
        mem_ack = 1'b0;
        check_b("st_done_busy", BUSY, 1'b0);
        check_b("st_done_req", mem_req, 1'b0);
        check("st_done_rdata", Rdata, 32'h0);
        bmem[waddr] = d;
        if (hit)
            mdata[idx][off] = d;
        tick();
        MEM = MEM_NONE;
        #1;
    endtask

    task automatic spurious_ack();
        MEM       = MEM_NONE;
        Addr      = $urandom;
        mem_ack   = 1'b1;
        mem_rdata = $urandom;
        #1;
        check_b("spur_busy", BUSY, 1'b0);
        check_b("spur_req", mem_req, 1'b0);
        check("spur_rdata", Rdata, 32'h0);
        tick();
        mem_ack = 1'b0;
        check_b("spur_busy_after", BUSY, 1'b0);
        check_b("spur_req_after", mem_req, 1'b0);
    endtask

    initial begin
        logic [31:0] ra;
        int          op;
        MEM       = MEM_LOAD;
        Addr      = 32'h40;
        Wdata     = 32'h0;
        mem_rdata = 32'h0;
        mem_ack   = 1'b0;
        rst       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_b("reset_busy", BUSY, 1'b0);
        check_b("reset_req", mem_req, 1'b0);
        check_b("reset_we", mem_we, 1'b0);
        check("reset_addr", mem_addr, 32'h0);
        check("reset_wdata", mem_wdata, 32'h0);
        check("reset_rdata", Rdata, 32'h0);
        check("reset_state", 32'(dbg_state), 32'(IDLE));
        MEM = MEM_NONE;
        #2;
        rst = 1'b1;
        tick();

        bmem[32'h40] = 32'h11;
        bmem[32'h44] = 32'h22;
        bmem[32'h48] = 32'h33;
        bmem[32'h4C] = 32'h44;
        do_load(32'h0000_0040, 0);
        do_load(32'h0000_0048, 0);
        do_store(32'h0000_0044, 32'hDEAD_BEEF);
        do_load(32'h0000_0044, 0);
        do_store(32'h0000_1044, 32'h0000_CAFE);
        do_load(32'h0000_1044, 0);
        do_load(32'h0000_1048, 0);
        do_load(32'h0000_0044, 0);
        do_load(32'h0000_0080, 2);
        tick();
        do_load(32'h0000_0080, 0);
        spurious_ack();
        do_load(32'h0000_0084, 0);
        do_load(32'h0000_0087, 0);

        for (int n = 0; n < 80; n++) begin
            ra = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, LINES - 1)) << 4)
               | (32'($urandom_range(0, WORDS - 1)) << 2) | 32'($urandom_range(0, 3));
            op = $urandom_range(0, 8);
            if (op < 5)
                do_load(ra, 0);
            else if (op < 8)
                do_store(ra, $urandom);
            else
                spurious_ack();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dcache_wt.md
DCACHE_WT -- requirements
Module: dcache_wt

Interface
REQ-001 SHALL have parameter LINES, default 16, number of direct-mapped lines (power of 2).
REQ-002 SHALL have parameter WORDS, default 4, 32-bit words per line (power of 2).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port MEM  input  2  request from memory stage: bit1=store, bit0=load, 00=none.
REQ-006 SHALL have port Addr  input  32  byte address; bits[1:0] ignored.
REQ-007 SHALL have port Wdata  input  32  store data.
REQ-008 SHALL have port Rdata  output  32  load data, valid when load request and BUSY=0.
REQ-009 SHALL have port BUSY  output  1  stall to pipeline control; request held stable while 1.
REQ-010 SHALL have port mem_req  output  1  backing-memory request.
REQ-011 SHALL have port mem_we  output  1  backing-memory write enable.
REQ-012 SHALL have port mem_addr  output  32  backing-memory word address (bits[1:0]=0).
REQ-013 SHALL have port mem_wdata  output  32  backing-memory write data.
REQ-014 SHALL have port mem_rdata  input  32  backing-memory read data, valid with mem_ack.
REQ-015 SHALL have port mem_ack  input  1  one-cycle completion pulse for current mem_req.

Function
REQ-016 SHALL decode Addr as offset=Addr[log2(WORDS)+1:2], index=next log2(LINES) bits, tag=remaining upper bits (defaults: [3:2], [7:4], [31:8]).
REQ-017 SHALL implement FSM states IDLE, FILL, WRITE, DONE.
REQ-018 IDLE, MEM=00: BUSY=0, no memory traffic.
REQ-019 IDLE, load hit (valid and tag match): Rdata=stored word combinationally, BUSY=0, stay IDLE.
REQ-020 IDLE, load miss: BUSY=1 same cycle, latch tag/index, word counter=0, go FILL.
REQ-021 FILL: mem_req=1, mem_we=0, mem_addr={tag,index,counter,2'b00}; each mem_ack writes mem_rdata to word[counter], counter increments.
REQ-022 FILL, mem_ack with counter=WORDS-1: set valid, write tag, go DONE.
REQ-023 IDLE, store (MEM[1]=1, MEM=11 treated as store): BUSY=1, go WRITE; write-through, no write-allocate.
REQ-024 WRITE: mem_req=1, mem_we=1, mem_addr={Addr[31:2],2'b00}, mem_wdata=Wdata; on mem_ack, if hit update the word, go DONE.
REQ-025 DONE: BUSY=0 for exactly one cycle, Rdata=addressed word for loads, unconditional return to IDLE.
REQ-026 BUSY SHALL be 1 in FILL and WRITE, including the cycle mem_ack arrives.
REQ-027 mem_req SHALL stay high and mem_addr/mem_we/mem_wdata stable until mem_ack.
REQ-028 mem_ack while mem_req=0 SHALL be ignored.
REQ-029 Rdata SHALL be 0 whenever no load is being returned.
REQ-030 Miss latency SHALL be WORDS ack-cycles plus one cycle (DONE); hit latency 0 stall cycles.

Reset
REQ-031 rst low SHALL immediately force state IDLE, all valid bits 0, counter 0, BUSY=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, Rdata=0.
REQ-032 Reset mid-FILL SHALL leave the line invalid; partially written data SHALL NOT be visible as a hit.
REQ-033 Data and tag arrays need not be reset.

Structure
REQ-034 Shared package SHALL hold FSM state enum, default LINES/WORDS, and MEM encoding constants (MEM_NONE, MEM_LOAD, MEM_STORE).
REQ-035 Tag/valid/data storage SHALL be one sub-module dc_line_store (read port by index/offset, line-fill write port, word write port, valid clear); FSM and address muxing stay in dcache_wt.

Verification
REQ-036 Reset, then load 0x0000_0040, memory returns 0x11,0x22,0x33,0x44 with ack 2 cycles apart -> mem_addr 0x40,0x44,0x48,0x4C; BUSY high until DONE; Rdata=0x11 in DONE.
REQ-037 Then load 0x0000_0048 -> hit, BUSY=0 same cycle, Rdata=0x33, mem_req stays 0.
REQ-038 Store 0xDEADBEEF to 0x44 -> mem_req=1, mem_we=1, mem_addr=0x44 until ack; then load 0x44 hits with Rdata=0xDEADBEEF.
REQ-039 Store 0xCAFE to 0x1044 (miss) -> written through, no fill; load 0x1044 -> miss, fill from 0x1040; line index 4 now tag 0x10.
REQ-040 Assert rst after second ack of a fill to 0x80 -> outputs reset immediately; subsequent load 0x80 misses and refetches all 4 words.
REQ-041 Spurious mem_ack in IDLE with MEM=00 -> no state change, no array write, BUSY=0.
